// File: rtl/dmem_pipe.sv
// Byte-write data memory with a valid/ready request port, configurable read latency
// and a response buffer that absorbs consumer stalls without losing read data.
module dmem_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16384,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [DATA_WIDTH/8-1:0] req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err
);

  localparam int unsigned NB      = DATA_WIDTH / 8;
  localparam int unsigned LAT     = 1 + OUT_REG;
  localparam int unsigned FD      = LAT + 1;
  localparam logic [1:0]  LAT_C   = 2'(LAT);
  localparam logic [1:0]  FD_LAST = 2'(FD - 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  r_req_ready;
  logic [1:0]            r_out;
  logic                  w_acc;
  logic                  w_cons;
  logic                  w_in_range;
  logic [1:0]            w_out_nxt;

  logic                  r_v1;
  logic [DATA_WIDTH-1:0] r_q1;
  logic [NB-1:0]         r_we1;
  logic [DATA_WIDTH-1:0] r_wd1;
  logic                  r_err1;
  logic [DATA_WIDTH-1:0] w_m1;

  logic                  w_pv;
  logic [DATA_WIDTH-1:0] w_pd;
  logic                  w_pe;

  logic [DATA_WIDTH-1:0] r_fd [4];
  logic                  r_fe [4];
  logic [1:0]            r_wp;
  logic [1:0]            r_rp;
  logic [1:0]            r_fcnt;
  logic                  w_fempty;
  logic                  w_push;
  logic                  w_pop;

  assign req_ready  = r_req_ready;
  assign w_acc      = req_valid & r_req_ready & rst_n;
  assign w_in_range = ({1'b0, req_addr} < (ADDR_WIDTH + 1)'(DEPTH));

  // Read-first storage: the registered read returns the word as it was before this edge.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_q1 <= r_mem[req_addr];
      for (int unsigned b = 0; b < NB; b++) begin
        if (w_in_range && req_we[b]) begin
          r_mem[req_addr][b*8 +: 8] <= req_wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_we1  <= req_we;
      r_wd1  <= req_wdata;
      r_err1 <= ~w_in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= w_acc;
    end
  end

  always_comb begin
    w_m1 = r_q1;
    if (RDW_MODE != 0) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (r_we1[b]) w_m1[b*8 +: 8] = r_wd1[b*8 +: 8];
      end
    end
    if (r_err1) w_m1 = '0;
  end

  if (OUT_REG != 0) begin : g_oreg
    logic                  r_v2;
    logic [DATA_WIDTH-1:0] r_d2;
    logic                  r_e2;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_v2 <= 1'b0;
      end else begin
        r_v2 <= r_v1;
      end
    end

    always_ff @(posedge clk) begin
      r_d2 <= w_m1;
      r_e2 <= r_err1;
    end

    assign w_pv = r_v2;
    assign w_pd = r_d2;
    assign w_pe = r_e2;
  end else begin : g_noreg
    assign w_pv = r_v1;
    assign w_pd = w_m1;
    assign w_pe = r_err1;
  end

  // The pipeline output bypasses the buffer when it is empty, so LAT=1 data is
  // visible right after acceptance; it is captured only if not taken this edge.
  assign w_fempty   = (r_fcnt == 2'd0);
  assign resp_valid = ~w_fempty | w_pv;
  assign w_pop      = ~w_fempty & resp_ready;
  assign w_push     = w_pv & ~(w_fempty & resp_ready);
  assign w_cons     = resp_valid & resp_ready;

  always_comb begin
    resp_rdata = '0;
    resp_err   = 1'b0;
    if (!w_fempty) begin
      resp_rdata = r_fd[r_rp];
      resp_err   = r_fe[r_rp];
    end else if (w_pv) begin
      resp_rdata = w_pd;
      resp_err   = w_pe;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fd[r_wp] <= w_pd;
      r_fe[r_wp] <= w_pe;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_push) r_wp <= (r_wp == FD_LAST) ? 2'd0 : r_wp + 2'd1;
      if (w_pop)  r_rp <= (r_rp == FD_LAST) ? 2'd0 : r_rp + 2'd1;
      r_fcnt <= r_fcnt + 2'(w_push) - 2'(w_pop);
    end
  end

  // Outstanding never exceeds LAT+1, so the buffer can always absorb the pipeline.
  assign w_out_nxt = r_out + 2'(w_acc) - 2'(w_cons);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_req_ready <= 1'b0;
    end else begin
      r_out       <= w_out_nxt;
      r_req_ready <= (w_out_nxt <= LAT_C);
    end
  end

endmodule

// File: tb/tb_dmem_pipe.sv
// Scoreboard bench for dmem_pipe: two instances (LAT=1/RDW old, LAT=2/RDW merged)
// checked against a plain array model of memory and an in-order expected-response queue.
module tb_dmem_pipe;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [3:0]  req_we     [2];
  logic [9:0]  req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  logic [31:0] mdl0 [1000];
  logic [31:0] mdl1 [1000];
  exp_t        q0[$];
  exp_t        q1[$];

  int          n_checks = 0;
  int          n_pass   = 0;
  bit          in_rst   = 1'b1;
  bit          rr_rand  = 1'b0;
  bit          stall    [2];
  logic [31:0] sd       [2];
  logic        se       [2];

  always #5 clk = ~clk;

  dmem_pipe #(.DATA_WIDTH(32), .DEPTH(1000), .ADDR_WIDTH(10), .OUT_REG(0), .RDW_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]));

  dmem_pipe #(.DATA_WIDTH(32), .DEPTH(1000), .ADDR_WIDTH(10), .OUT_REG(1), .RDW_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]));

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic int qsize(int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  // Reference: whole-word memory; reads return the prior word, writes return old
  // (instance 0) or merged (instance 1) word; out-of-range returns 0 with error.
  function automatic void model_accept(int k, logic [3:0] we, logic [9:0] addr, logic [31:0] wd);
    exp_t        e;
    logic [31:0] old;
    logic [31:0] nw;
    bit          inr;
    inr = (addr < 10'd1000);
    old = '0;
    if (inr) old = (k == 0) ? mdl0[addr] : mdl1[addr];
    nw = old;
    for (int i = 0; i < 4; i++) if (we[i]) nw[i*8 +: 8] = wd[i*8 +: 8];
    e.e = !inr;
    e.d = !inr ? 32'd0 : ((k == 1 && we != 4'd0) ? nw : old);
    if (inr) begin
      if (k == 0) mdl0[addr] = nw;
      else        mdl1[addr] = nw;
    end
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic logic [9:0] raddr();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return 10'd999;
    if (r == 1) return 10'($urandom_range(1000, 1023));
    return 10'($urandom_range(0, 63));
  endfunction

  task automatic mon(int k);
    exp_t e;
    logic v;
    logic [31:0] d;
    logic er;
    v  = resp_valid[k];
    d  = resp_rdata[k];
    er = resp_err[k];
    if (in_rst) stall[k] = 1'b0;
    else if (stall[k]) chk($sformatf("stable%0d", k), {v, d, er}, {1'b1, sd[k], se[k]});
    if (!v) chk($sformatf("idle_zero%0d", k), {d, er}, 33'd0);
    if (v && resp_ready[k] && !in_rst) begin
      if (qsize(k) == 0) begin
        n_checks++;
        $display("FAIL unexpected_resp%0d: got %0h with no response outstanding", k, d);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("resp%0d", k), {d, er}, {e.d, e.e});
      end
    end
    stall[k] = v && !resp_ready[k];
    sd[k]    = d;
    se[k]    = er;
  endtask

  always begin
    @(negedge clk);
    #4;
    mon(0);
    mon(1);
  end

  task automatic issue(input int k, input logic [3:0] we, input logic [9:0] addr,
                       input logic [31:0] wd, output int waits);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wd;
    waits = 0;
    if (rr_rand) resp_ready[k] = 1'($urandom_range(0, 1));
    while (!req_ready[k] && waits < 100) begin
      @(negedge clk);
      waits++;
      if (rr_rand) resp_ready[k] = 1'($urandom_range(0, 1));
    end
    if (!req_ready[k]) begin
      n_checks++;
      $display("FAIL accept_timeout%0d: req_ready stayed %0d, required 1", k, req_ready[k]);
    end else begin
      model_accept(k, we, addr, wd);
    end
    @(negedge clk);
    req_valid[k] = 1'b0;
    req_we[k]    = 4'($urandom);
    req_addr[k]  = 10'($urandom);
    req_wdata[k] = $urandom;
  endtask

  task automatic drain(input int k);
    int n;
    resp_ready[k] = 1'b1;
    n = 0;
    while (qsize(k) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (qsize(k) != 0) begin
      n_checks++;
      $display("FAIL drain_timeout%0d: %0d responses missing, required 0", k, qsize(k));
    end
    chk($sformatf("drain_idle%0d", k), resp_valid[k], 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int w;
    int tw;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k]  = 1'b0;
      req_we[k]     = '0;
      req_addr[k]   = '0;
      req_wdata[k]  = '0;
      resp_ready[k] = 1'b1;
      stall[k]      = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_ready%0d", k), req_ready[k], 1'b0);
      chk($sformatf("rst_valid%0d", k), resp_valid[k], 1'b0);
      chk($sformatf("rst_data%0d", k), {resp_rdata[k], resp_err[k]}, 33'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk($sformatf("rel_ready%0d", k), req_ready[k], 1'b1);
    in_rst = 1'b0;

    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 64; a++) issue(k, 4'hF, 10'(a), $urandom, w);
      issue(k, 4'hF, 10'd999, $urandom, w);
      drain(k);

      // byte merge and exact latency
      issue(k, 4'hF, 10'd5, 32'hDEADBEEF, w);
      issue(k, 4'b0010, 10'd5, 32'h0000AA00, w);
      drain(k);
      issue(k, 4'h0, 10'd5, 32'h0, w);
      if (k == 1) begin
        chk("lat2_early", resp_valid[k], 1'b0);
        @(negedge clk);
      end
      chk($sformatf("lat_valid%0d", k), resp_valid[k], 1'b1);
      chk($sformatf("merge%0d", k), resp_rdata[k], 32'hDEADAAEF);
      drain(k);

      // read-during-write response
      issue(k, 4'hF, 10'd9, 32'h11111111, w);
      drain(k);
      issue(k, 4'h3, 10'd9, 32'h22222222, w);
      if (k == 1) @(negedge clk);
      chk($sformatf("rdw%0d", k), resp_rdata[k], (k == 0) ? 32'h11111111 : 32'h11112222);
      drain(k);

      // backpressure: LAT+1 accepted, then stall
      resp_ready[k] = 1'b0;
      for (int a = 0; a <= k + 1; a++) begin
        issue(k, 4'h0, 10'(a), 32'h0, w);
        chk($sformatf("bp_accept%0d", k), w, 0);
      end
      req_valid[k] = 1'b1;
      req_we[k]    = 4'h0;
      req_addr[k]  = 10'(k + 2);
      repeat (3) begin
        chk($sformatf("bp_full%0d", k), {req_ready[k], resp_valid[k]}, 2'b01);
        @(negedge clk);
      end
      resp_ready[k] = 1'b1;
      for (int a = k + 2; a < 6; a++) begin
        issue(k, 4'h0, 10'(a), 32'h0, w);
        if (a > k + 2) chk($sformatf("bp_flow%0d", k), w, 0);
      end
      drain(k);

      // sustained throughput
      tw = 0;
      for (int i = 0; i < 100; i++) begin
        issue(k, (i % 2 == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
              10'($urandom_range(0, 63)), $urandom, w);
        tw += w;
      end
      chk($sformatf("throughput%0d", k), tw, 0);
      drain(k);

      // random consumer stalls with occasional out-of-range traffic
      rr_rand = 1'b1;
      for (int i = 0; i < 150; i++) begin
        issue(k, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0, raddr(), $urandom, w);
      end
      rr_rand = 1'b0;
      drain(k);

      // out of range
      issue(k, 4'hF, 10'd1000, 32'hCAFEBABE, w);
      issue(k, 4'h0, 10'd1000, 32'h0, w);
      issue(k, 4'h0, 10'd999, 32'h0, w);
      drain(k);
    end

    // reset with two requests outstanding
    resp_ready[1] = 1'b0;
    issue(1, 4'hF, 10'd20, 32'h12345678, w);
    issue(1, 4'h0, 10'd7, 32'h0, w);
    in_rst = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_valid", resp_valid[1], 1'b0);
    chk("mid_rst_ready", req_ready[1], 1'b0);
    resp_ready[1] = 1'b1;
    @(negedge clk);
    chk("mid_rst_rel", req_ready[1], 1'b1);
    in_rst = 1'b0;
    repeat (4) begin
      chk("no_stale", resp_valid[1], 1'b0);
      @(negedge clk);
    end
    issue(1, 4'h0, 10'd20, 32'h0, w);
    issue(1, 4'h0, 10'd5, 32'h0, w);
    issue(0, 4'h0, 10'd9, 32'h0, w);
    drain(1);
    drain(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_pipe.md
Name: dmem_pipe

Overview:
- Parametrised byte-write data memory with a valid/ready request port and a buffered response port.
- Successor to the fixed 32-bit × 16K data memory; data width, depth, read latency and read-during-write mode are configurable.
- Adds backpressure, out-of-range detection and a response buffer, so the CPU or DMA consumer may stall without losing read data.
- Sits between the load/store unit (or an arbiter) and block RAM.

Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- DEPTH, 16384: number of words; need not be a power of two.
- ADDR_WIDTH, $clog2(DEPTH): word-address width.
- OUT_REG, 0: 1 adds a RAM output register stage, giving read latency LAT = 1 + OUT_REG.
- RDW_MODE, 0: on a write request, resp_rdata returns the old word (0) or the merged new word (1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this edge if req_valid=1.
- req_we  in  DATA_WIDTH/8  byte write mask; all-zero means a read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response this edge.
- resp_rdata  out  DATA_WIDTH  read data.
- resp_err  out  1  the request's address was >= DEPTH.

Behaviour:
- Reset (rst_n=0 at an edge):
  - Clears the outstanding count, pipeline valid bits and response buffer.
  - Outputs: req_ready=0 while rst_n=0 and 1 from the first edge after release; resp_valid=0, resp_rdata=0, resp_err=0.
  - Memory contents are preserved.
  - Requests in flight when reset is applied mid-operation are dropped with no response.
- Handshakes:
  - A request is accepted on an edge with req_valid & req_ready.
  - A response is consumed on an edge with resp_valid & resp_ready.
  - Every accepted request (read or write) produces exactly one response, in order.
- Write:
  - On acceptance, each byte i with req_we[i]=1 is written; bytes with req_we[i]=0 are unchanged.
- Response data:
  - Read: the word as stored before this edge.
  - Write: governed by RDW_MODE.
    - 0: old word.
    - 1: old word with the enabled bytes replaced by req_wdata.
- Ordering: a request accepted on the edge after a write to the same address observes the written data, with no hazard in either mode.
- Latency:
  - Request accepted on edge t, response buffer empty → resp_valid=1 in the cycle after edge t+LAT-1.
  - LAT=1 means data is visible the cycle after acceptance.
- Response buffer:
  - Depth LAT+1, FIFO order.
  - resp_valid=1 iff the buffer is non-empty.
  - resp_rdata, resp_err are held stable while resp_valid=1 and resp_ready=0.
  - resp_rdata=0 and resp_err=0 whenever resp_valid=0.
- Flow control:
  - outstanding = accepted minus consumed, range 0..LAT+1.
  - req_ready = (outstanding <= LAT) & reset released.
  - req_ready is registered, with no combinational path from resp_ready.
  - Simultaneous accept and consume leaves outstanding unchanged.
  - Sustained throughput is one request per cycle while resp_ready=1.
  - With resp_ready=0, exactly LAT+1 requests are accepted, then req_ready=0.
- Out of range (req_addr >= DEPTH):
  - No memory write.
  - Response has resp_rdata=0, resp_err=1.
  - Flow control is otherwise normal.
- req_we, req_addr and req_wdata are ignored unless the request is accepted.
- Memory must infer block RAM: a single synchronous read port with byte-write enables, and no reset on the storage array.

Test Plan:
- Byte merge, LAT=1: write 0xDEADBEEF with req_we=4'hF to addr 5, then req_we=4'b0010 with wdata 0x0000AA00, then read addr 5 → resp_rdata=0xDEADAAEF exactly one cycle after acceptance.
- RDW_MODE: addr 9 holds 0x11111111; write 0x22222222 with req_we=4'h3.
  - RDW_MODE=0 → response 0x11111111.
  - RDW_MODE=1 → response 0x11112222.
- Backpressure, OUT_REG=1, resp_ready=0:
  - Issue reads of addrs 0..5 → exactly 3 accepted, then req_ready=0.
  - Raise resp_ready → responses arrive in order for addrs 0,1,2, with data stable while stalled.
  - Remaining reads then flow one per cycle.
- Throughput: resp_ready=1, 100 back-to-back alternating writes and reads to random addresses → req_ready never drops; every read matches a scoreboard model.
- Out of range, DEPTH=1000: write to addr 1000, then read addr 1000 → both responses have resp_err=1 and rdata 0; addr 999 is unaffected.
- Reset mid-operation: 2 requests outstanding, assert rst_n=0 for 1 cycle → resp_valid=0 the next cycle, no stale responses afterwards, and previously written data is still readable.
